// File: rtl/branch_predictor_if.sv
// Resolved-branch report channel from the branch unit to the branch predictor.
interface bru_predictor_interface;
    logic        valid;
    logic [31:0] inst_pc;
    logic        branch_taken;
    logic [31:0] branch_target;

    modport bru (
        output valid, inst_pc, branch_taken, branch_target
    );

    modport predictor (
        input valid, inst_pc, branch_taken, branch_target
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, trained by branch-unit reports.
// Optional macro BP_BYPASS_EN forwards a same-cycle update of the fetched PC into the prediction.
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    bru_predictor_interface.predictor         bru,
    input  logic [31:0]                       fetch_pc,
    output logic                              pred_taken,
    output logic [31:0]                       pred_target
);
    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    logic                valid_q  [ENTRIES];
    logic [1:0]          cnt_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    logic [INDEX_BITS-1:0] fetch_idx, upd_idx;
    logic [TAG_BITS-1:0]   fetch_tag, upd_tag;
    logic                  fetch_hit, upd_hit;
    logic                  upd_write;
    logic                  new_valid;
    logic [1:0]            new_cnt;
    logic [31:0]           new_target;
    logic [31:0]           seq_pc;
    logic [1:0]            unused_pc_low;

    assign unused_pc_low = bru.inst_pc[1:0];

    assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
    assign fetch_tag = fetch_pc[31:INDEX_BITS+2];
    assign upd_idx   = bru.inst_pc[INDEX_BITS+1:2];
    assign upd_tag   = bru.inst_pc[31:INDEX_BITS+2];
    assign seq_pc    = fetch_pc + 32'd4;

    assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Next state of the entry addressed by the update; also feeds the bypass path.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        new_valid  = upd_hit;
        new_cnt    = cnt_q[upd_idx];
        new_target = target_q[upd_idx];
        upd_write  = 1'b0;
        if (bru.valid) begin
            if (upd_hit) begin
                upd_write = 1'b1;
                if (bru.branch_taken) begin
                    new_cnt    = (cnt_q[upd_idx] == 2'd3) ? 2'd3 : cnt_q[upd_idx] + 2'd1;
                    new_target = bru.branch_target;
                end else begin
                    new_cnt    = (cnt_q[upd_idx] == 2'd0) ? 2'd0 : cnt_q[upd_idx] - 2'd1;
                end
            end else if (bru.branch_taken) begin
                upd_write  = 1'b1;
                new_valid  = 1'b1;
                new_cnt    = 2'd2;
                new_target = bru.branch_target;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'd1;
            end
        end else if (upd_write) begin
            valid_q[upd_idx] <= new_valid;
            cnt_q[upd_idx]   <= new_cnt;
        end
    end

    // NOTE: tag/target storage is deliberately not reset; valid gates it, so it can map to plain RAM.
    always_ff @(posedge clk) begin
        if (bru.valid && bru.branch_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= bru.branch_target;
        end
    end

`ifdef BP_BYPASS_EN
    logic bypass;
    logic fwd_taken;
    assign bypass    = bru.valid && (fetch_pc[31:2] == bru.inst_pc[31:2]);
    assign fwd_taken = new_valid && new_cnt[1];

    always_comb begin
        pred_taken  = fetch_hit && cnt_q[fetch_idx][1];
        pred_target = pred_taken ? target_q[fetch_idx] : seq_pc;
        if (bypass) begin
            pred_taken  = fwd_taken;
            pred_target = fwd_taken ? new_target : seq_pc;
        end
    end
`else
    assign pred_taken  = fetch_hit && cnt_q[fetch_idx][1];
    assign pred_target = pred_taken ? target_q[fetch_idx] : seq_pc;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: training, saturation, aliasing, reset and same-cycle lookup.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    int          n_checks = 0;
    int          n_fail   = 0;

    bru_predictor_interface bru_if ();

    branch_predictor #(.INDEX_BITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bru         (bru_if),
        .fetch_pc    (fetch_pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds the report across one posedge, returns at the next negedge.
    task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        bru_if.valid         = 1'b1;
        bru_if.inst_pc       = pc;
        bru_if.branch_taken  = tk;
        bru_if.branch_target = tgt;
        @(negedge clk);
        bru_if.valid = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tgt);
        fetch_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        check({tag, "_target"}, pred_target, exp_tgt);
    endtask

    initial begin
        rst                  = 1'b1;
        fetch_pc             = 32'h1C00_0000;
        bru_if.valid         = 1'b0;
        bru_if.inst_pc       = 32'h0;
        bru_if.branch_taken  = 1'b0;
        bru_if.branch_target = 32'h0;

        @(negedge clk);
        look("in_reset", 32'h1C00_0000, 1'b0, 32'h1C00_0004);
        rst = 1'b0;
        @(negedge clk);
        look("after_reset", 32'h1C00_0000, 1'b0, 32'h1C00_0004);

        // Allocation and counter training on one branch
        do_update(32'h1C00_0010, 1'b1, 32'h1C00_0100);
        look("alloc_cnt2", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
        do_update(32'h1C00_0010, 1'b1, 32'h1C00_0100);
        look("cnt3", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
        do_update(32'h1C00_0010, 1'b1, 32'h1C00_0100);
        look("cnt3_sat", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
        do_update(32'h1C00_0010, 1'b0, 32'hDEAD_BEEF);
        look("cnt2_nt", 32'h1C00_0010, 1'b1, 32'h1C00_0100);
        do_update(32'h1C00_0010, 1'b0, 32'hDEAD_BEEF);
        look("cnt1_nt", 32'h1C00_0010, 1'b0, 32'h1C00_0014);
        do_update(32'h1C00_0010, 1'b0, 32'h0);
        look("cnt0", 32'h1C00_0010, 1'b0, 32'h1C00_0014);
        do_update(32'h1C00_0010, 1'b0, 32'h0);
        look("cnt0_sat", 32'h1C00_0010, 1'b0, 32'h1C00_0014);
        do_update(32'h1C00_0010, 1'b1, 32'h1C00_0200);
        look("cnt1_from0", 32'h1C00_0010, 1'b0, 32'h1C00_0014);
        do_update(32'h1C00_0010, 1'b1, 32'h1C00_0200);
        look("cnt2_newtgt", 32'h1C00_0010, 1'b1, 32'h1C00_0200);

        // Aliasing replacement at index 0
        do_update(32'h0000_0040, 1'b1, 32'h0000_1000);
        look("alias_a_hit", 32'h0000_0040, 1'b1, 32'h0000_1000);
        do_update(32'h0000_0080, 1'b1, 32'h0000_2000);
        look("alias_a_evicted", 32'h0000_0040, 1'b0, 32'h0000_0044);
        look("alias_b_hit", 32'h0000_0080, 1'b1, 32'h0000_2000);

        // Not-taken miss never allocates or evicts
        do_update(32'h0000_0200, 1'b0, 32'h0000_3000);
        look("nt_no_alloc", 32'h0000_0200, 1'b0, 32'h0000_0204);
        look("nt_no_evict", 32'h0000_0080, 1'b1, 32'h0000_2000);

        // Low PC bits ignored; sequential target wraps
        look("pc_low_bits", 32'h0000_0082, 1'b1, 32'h0000_2000);
        do_update(32'h0000_0203, 1'b1, 32'h0000_4000);
        look("upd_low_bits", 32'h0000_0200, 1'b1, 32'h0000_4000);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Mid-sequence reset clears immediately and drops a concurrent update
        rst = 1'b1;
        look("async_rst_miss", 32'h0000_0080, 1'b0, 32'h0000_0084);
        do_update(32'h0000_0080, 1'b1, 32'h0000_5000);
        rst = 1'b0;
        look("rst_drop_upd", 32'h0000_0080, 1'b0, 32'h0000_0084);
        look("rst_cleared", 32'h1C00_0010, 1'b0, 32'h1C00_0014);

        // Same-cycle update and lookup of one PC
        fetch_pc             = 32'h1C00_0010;
        bru_if.valid         = 1'b1;
        bru_if.inst_pc       = 32'h1C00_0010;
        bru_if.branch_taken  = 1'b1;
        bru_if.branch_target = 32'h1C00_0100;
        #1;
`ifdef BP_BYPASS_EN
        check("same_cycle_taken", {31'd0, pred_taken}, 32'd1);
        check("same_cycle_target", pred_target, 32'h1C00_0100);
`else
        check("same_cycle_taken", {31'd0, pred_taken}, 32'd0);
        check("same_cycle_target", pred_target, 32'h1C00_0014);
`endif
        @(negedge clk);
        bru_if.valid = 1'b0;
        look("next_cycle", 32'h1C00_0010, 1'b1, 32'h1C00_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
